// File: rtl/avr_serial_tx.sv
// avr_serial_tx: byte-wide UART transmitter for the FPGA-to-AVR serial line.
// Frames are 8N1, LSB first. Transmission is gated by the AVR being configured
// (ready, registered into tx_oe) and by the AVR's flow-control line (tx_block).
module avr_serial_tx #(
    parameter int CLK_RATE    = 50000000,
    parameter int BAUD_RATE   = 500000,
    parameter int CLK_PER_BIT = CLK_RATE / BAUD_RATE,  // must be >= 2
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       tx_block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Last count of a bit period; the counter never goes past this value.
    localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

    state_t              state_q;
    logic [CTR_SIZE-1:0] ctr_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q;
    logic                tx_q;
    logic                oe_q;
    logic                sync_q;
    logic                block_q;
    logic                bit_end;

    assign bit_end = (ctr_q == CTR_LAST);
    assign busy    = (state_q != IDLE) | block_q | ~oe_q;
    assign tx      = tx_q;
    assign tx_oe   = oe_q;

    // tx_block is asynchronous: two-flop synchroniser that resets to "blocked",
    // plus a one-cycle registered copy of ready used as the tristate enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b1;
            block_q <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            sync_q  <= tx_block;
            block_q <= sync_q;
            oe_q    <= ready;
        end
    end

    // Frame sequencer: start bit, eight data bits, stop bit; aborts cleanly
    // back to idle whenever the output enable has dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ctr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else if (!oe_q) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ctr_q   <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (new_data && !busy) begin
                        shift_q <= data;
                        ctr_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        ctr_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        ctr_q <= ctr_q + CTR_SIZE'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        ctr_q   <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        ctr_q <= ctr_q + CTR_SIZE'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        ctr_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        ctr_q <= ctr_q + CTR_SIZE'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ctr_q   <= '0;
                    bit_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_serial_tx.sv
// tb_avr_serial_tx: table-driven frame checks plus hand-written sequences for
// reset, flow control, ready abort and back-to-back frames. A background
// receiver decodes every frame on tx and compares it to a queue of expected bytes.
module tb_avr_serial_tx;

    localparam int CLK_PER_BIT = 100;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       ready   = 1'b1;
    logic       txBlock = 1'b0;
    logic       newData = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       tx;
    logic       txOe;
    logic       busy;

    int         passCount  = 0;
    int         totalCount = 0;
    logic [7:0] expQ[$];
    bit         rxEnable   = 1'b1;

    typedef struct {
        logic [7:0] dataIn;
        logic [7:0] expByte;
        logic [9:0] expFrame;   // index 0 = start bit, 9 = stop bit
        int         mode;       // 0 plain, 1 poke new_data mid-frame
    } vector_t;

    vector_t vectors[4];

    avr_serial_tx #(
        .CLK_RATE (50000000),
        .BAUD_RATE(500000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .tx_block(txBlock),
        .data    (data),
        .new_data(newData),
        .tx      (tx),
        .tx_oe   (txOe),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for busy to clear, then strobes new_data for one cycle.
    // Returns on the falling edge just after the accepting rising edge.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] expB, input bit push);
        int waited = 0;
        while (busy && waited < 3000) begin
            tick();
            waited++;
        end
        if (busy) begin
            checkOutput("stimulus wait for idle", 32'(busy), 32'd0);
            return;
        end
        data    = b;
        newData = 1'b1;
        if (push) expQ.push_back(expB);
        tick();
        newData = 1'b0;
    endtask

    // Walks one full frame from the first cycle after acceptance, checking tx
    // mid-bit and busy at the frame boundary. Mode 2 raises tx_block mid-frame.
    task automatic watchFrame(input logic [9:0] frame, input int mode, input string name);
        for (int t = 0; t < 10 * CLK_PER_BIT; t++) begin
            if (t % CLK_PER_BIT == CLK_PER_BIT / 2)
                checkOutput($sformatf("%s bit %0d", name, t / CLK_PER_BIT), 32'(tx), 32'(frame[t / CLK_PER_BIT]));
            if (t == 50) checkOutput({name, " busy mid-frame"}, 32'(busy), 32'd1);
            if (mode == 1 && t == 50) begin
                newData = 1'b1;
                data    = 8'h3C;
            end
            if (mode == 1 && t == 60) begin
                newData = 1'b0;
                data    = 8'h00;
            end
            if (mode == 2 && t == 450) txBlock = 1'b1;
            if (t == 10 * CLK_PER_BIT - 1) checkOutput({name, " busy in stop"}, 32'(busy), 32'd1);
            tick();
        end
        checkOutput({name, " busy after frame"}, 32'(busy), (mode == 2) ? 32'd1 : 32'd0);
    endtask

    // Background receiver: decodes each frame on tx and scores it against expQ.
    initial begin : receiver
        bit         active = 1'b0;
        int         count  = 0;
        logic [7:0] rxByte = 8'h00;
        logic [7:0] expByte;
        forever begin
            @(negedge clk);
            if (!rxEnable || rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    count  = 0;
                    rxByte = 8'h00;
                end
            end else begin
                count++;
                if (count == CLK_PER_BIT / 2) checkOutput("rx start bit", 32'(tx), 32'd0);
                for (int k = 0; k < 8; k++)
                    if (count == CLK_PER_BIT * (k + 1) + CLK_PER_BIT / 2) rxByte[k] = tx;
                if (count == CLK_PER_BIT * 9 + CLK_PER_BIT / 2) begin
                    checkOutput("rx stop bit", 32'(tx), 32'd1);
                    if (expQ.size() == 0) begin
                        totalCount++;
                        $display("[TB] FAIL rx unexpected frame: got 0x%0h, expected no frame", rxByte);
                    end else begin
                        expByte = expQ.pop_front();
                        checkOutput("rx byte", 32'(rxByte), 32'(expByte));
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        vectors[0] = '{8'hA5, 8'hA5, 10'b1101001010, 1};
        vectors[1] = '{8'h5A, 8'h5A, 10'b1010110100, 0};
        vectors[2] = '{8'h81, 8'h81, 10'b1100000010, 0};
        vectors[3] = '{8'h00, 8'h00, 10'b1000000000, 0};

        // Reset and post-reset busy window
        $display("[TB] reset");
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("reset tx", 32'(tx), 32'd1);
            checkOutput("reset tx_oe", 32'(txOe), 32'd0);
            checkOutput("reset busy", 32'(busy), 32'd1);
        end
        rst = 1'b0;
        tick();
        checkOutput("release+1 busy", 32'(busy), 32'd1);
        checkOutput("release+1 tx_oe", 32'(txOe), 32'd1);
        tick();
        tick();
        checkOutput("release+3 busy", 32'(busy), 32'd0);
        checkOutput("release+3 tx", 32'(tx), 32'd1);

        // Table-driven single frames
        $display("[TB] table vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].dataIn, vectors[i].expByte, 1'b1);
            watchFrame(vectors[i].expFrame, vectors[i].mode, $sformatf("vec%0d", i));
        end

        // Flow control raised during data bit 3, next byte waits for release
        $display("[TB] flow control");
        applyStimulus(8'h55, 8'h55, 1'b1);
        watchFrame(10'b1010101010, 2, "block");
        newData = 1'b1;
        data    = 8'h0F;
        expQ.push_back(8'h0F);
        repeat (100) tick();
        checkOutput("blocked busy", 32'(busy), 32'd1);
        checkOutput("blocked tx idle", 32'(tx), 32'd1);
        txBlock = 1'b0;
        tick();
        checkOutput("unblock+1 busy", 32'(busy), 32'd1);
        tick();
        checkOutput("unblock+2 busy", 32'(busy), 32'd0);
        checkOutput("unblock+2 tx", 32'(tx), 32'd1);
        tick();
        newData = 1'b0;
        data    = 8'h00;
        watchFrame(10'b1000011110, 0, "after block");

        // ready dropped during data bit 5 aborts the frame
        $display("[TB] ready drop");
        rxEnable = 1'b0;
        applyStimulus(8'hC3, 8'hC3, 1'b0);
        repeat (650) tick();
        ready = 1'b0;
        tick();
        checkOutput("drop+1 tx_oe", 32'(txOe), 32'd0);
        checkOutput("drop+1 tx still bit5", 32'(tx), 32'd0);
        tick();
        checkOutput("drop+2 tx", 32'(tx), 32'd1);
        checkOutput("drop+2 busy", 32'(busy), 32'd1);
        repeat (20) tick();
        checkOutput("dropped tx idle", 32'(tx), 32'd1);
        ready = 1'b1;
        tick();
        checkOutput("ready back tx_oe", 32'(txOe), 32'd1);
        checkOutput("ready back busy", 32'(busy), 32'd0);
        rxEnable = 1'b1;
        applyStimulus(8'h81, 8'h81, 1'b1);
        watchFrame(10'b1100000010, 0, "after abort");

        // Back-to-back frames with new_data held high
        $display("[TB] back-to-back");
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        newData = 1'b1;
        data    = 8'h00;
        expQ.push_back(8'h00);
        watchFrame(10'b1111111110, 0, "b2b first");
        checkOutput("b2b idle gap tx", 32'(tx), 32'd1);
        tick();
        checkOutput("b2b second start tx", 32'(tx), 32'd0);
        checkOutput("b2b second busy", 32'(busy), 32'd1);
        newData = 1'b0;
        watchFrame(10'b1000000000, 0, "b2b second");

        repeat (20) tick();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
